// File: rtl/exec_alu_unit.sv
// exec_alu_unit: execute-stage ALU with valid/ready handshakes on both sides.
// Define EXEC_ALU_FAST_SHIFT_EN to use a single-cycle barrel shifter.
module exec_alu_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal_op
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_BGE = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;

`ifdef EXEC_ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] res_d;
    logic             ill_d;

    assign amt        = op_b[SHW-1:0];
    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign illegal_op = illegal_q;

`ifndef EXEC_ALU_FAST_SHIFT_EN
    logic [WIDTH-1:0] sh_q;
    logic [SHW-1:0]   cnt_q;
    logic [1:0]       kind_q;
    logic [WIDTH-1:0] sh_step;
    logic             is_shift;

    assign is_shift = (ALUControl == OP_SLL) ||
                      (ALUControl == OP_SRL) ||
                      (ALUControl == OP_SRA);

    // One-bit shift of the working register; kind is ALUControl[1:0].
    always_comb begin
        sh_step = sh_q;
        case (kind_q)
            2'b00:   sh_step = {sh_q[WIDTH-2:0], 1'b0};
            2'b10:   sh_step = {1'b0, sh_q[WIDTH-1:1]};
            default: sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        endcase
    end
`endif

    // Single-cycle result; iterative shifts only use this for amount 0.
    always_comb begin
        res_d = '0;
        ill_d = 1'b0;
        case (ALUControl)
            OP_ADD: res_d = op_a + op_b;
            OP_SUB: res_d = op_a - op_b;
            OP_AND: res_d = op_a & op_b;
            OP_OR:  res_d = op_a | op_b;
            OP_XOR: res_d = op_a ^ op_b;
            OP_SLT: res_d = {{(WIDTH-1){1'b0}},
                             ($signed(op_a) < $signed(op_b))};
            OP_BGE: res_d = {{(WIDTH-1){1'b0}},
                             ($signed(op_a) >= $signed(op_b))};
`ifdef EXEC_ALU_FAST_SHIFT_EN
            OP_SLL: res_d = op_a << amt;
            OP_SRL: res_d = op_a >> amt;
            OP_SRA: res_d = WIDTH'($signed(op_a) >>> amt);
`else
            OP_SLL: res_d = op_a;
            OP_SRL: res_d = op_a;
            OP_SRA: res_d = op_a;
`endif
            default: begin
                res_d = '0;
                ill_d = 1'b1;
            end
        endcase
    end

    // Control FSM with registered result, flags and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
`ifndef EXEC_ALU_FAST_SHIFT_EN
            sh_q        <= '0;
            cnt_q       <= '0;
            kind_q      <= 2'b00;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
`ifndef EXEC_ALU_FAST_SHIFT_EN
                        if (is_shift && (amt != '0)) begin
                            sh_q    <= op_a;
                            cnt_q   <= amt;
                            kind_q  <= ALUControl[1:0];
                            state_q <= S_SHIFT;
                        end else
`endif
                        begin
                            result_q    <= res_d;
                            zero_q      <= (res_d == '0);
                            illegal_q   <= ill_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
`ifndef EXEC_ALU_FAST_SHIFT_EN
                S_SHIFT: begin
                    sh_q  <= sh_step;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        result_q    <= sh_step;
                        zero_q      <= (sh_step == '0);
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_alu_unit.sv
// tb_exec_alu_unit: randomized and directed checks of exec_alu_unit
// against a behavioural model of the ALU operation set and latency.
module tb_exec_alu_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUControl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal_op;

    int errors = 0;
    int checks = 0;

    exec_alu_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(logic [3:0] op,
                                            logic [31:0] a,
                                            logic [31:0] b);
        int n;
        n = int'(b[4:0]);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a << n;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return a >> n;
            4'd7: return a[31] ? ~((~a) >> n) : (a >> n);
            4'd8: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(logic [3:0] op, logic [31:0] b);
`ifdef EXEC_ALU_FAST_SHIFT_EN
        return 1;
`else
        if ((op == 4'd4 || op == 4'd6 || op == 4'd7) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
`endif
    endfunction

    // Issue one op from IDLE, measure edges until out_valid, then drain it.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r,
                         output logic z, output logic il, output int lat);
        @(negedge clk);
        ALUControl = op;
        op_a       = a;
        op_b       = b;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r  = result;
        z  = zero;
        il = illegal_op;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ALUControl = 4'd0;
        op_a = '0;
        op_b = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 ||
            illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b r=%h z=%b il=%b want 0",
                     out_valid, result, zero, illegal_op);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic run_vec(input string nm, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic ez,
                           input int el);
        logic [31:0] r;
        logic z, il;
        int lat;
        do_op(op, a, b, r, z, il, lat);
        checks++;
        if (r !== er || z !== ez || il !== 1'b0 || lat !== el) begin
            errors++;
            $display("FAIL %s got r=%h z=%b il=%b lat=%0d want r=%h z=%b il=0 lat=%0d",
                     nm, r, z, il, lat, er, ez, el);
        end
    endtask

    task automatic test_arith();
        run_vec("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1);
        run_vec("sub_zero", 4'd1, 32'd5, 32'd5, 32'd0, 1'b1, 1);
        run_vec("slt_neg", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
        run_vec("bge_neg", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1);
        run_vec("bge_eq", 4'd8, 32'd3, 32'd3, 32'd1, 1'b0, 1);
        run_vec("xor", 4'd9, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0, 1);
    endtask

    task automatic test_shift();
        run_vec("sra31", 4'd7, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0,
                ref_lat(4'd7, 32'd31));
        run_vec("srl31", 4'd6, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0,
                ref_lat(4'd6, 32'd31));
        run_vec("sll0", 4'd4, 32'd1, 32'd0, 32'd1, 1'b0, 1);
        run_vec("sll_mask", 4'd4, 32'd5, 32'h23, 32'h28, 1'b0,
                ref_lat(4'd4, 32'h23));
        run_vec("srl_out", 4'd6, 32'h0000_0010, 32'd5, 32'd0, 1'b1,
                ref_lat(4'd6, 32'd5));
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        @(negedge clk);
        ALUControl = 4'd0;
        op_a = 32'h1234_0000;
        op_b = 32'h0000_5678;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        ALUControl = 4'd1;
        op_a = 32'hAAAA_AAAA;
        held = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== held || zero !== 1'b0 ||
                in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b r=%h z=%b rdy=%b want v=1 r=%h z=0 rdy=0",
                         i, out_valid, result, zero, in_ready, held);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== held) begin
            errors++;
            $display("FAIL bp_release got rdy=%b v=%b r=%h want rdy=1 v=0 r=%h",
                     in_ready, out_valid, result, held);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] r;
        logic z, il;
        int lat;
        do_op(4'b1100, 32'hDEAD_BEEF, 32'h1, r, z, il, lat);
        checks++;
        if (r !== 32'd0 || z !== 1'b1 || il !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL illegal got r=%h z=%b il=%b lat=%0d want r=0 z=1 il=1 lat=1",
                     r, z, il, lat);
        end
        do_op(4'd0, 32'd2, 32'd3, r, z, il, lat);
        checks++;
        if (r !== 32'd5 || il !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear got r=%h il=%b want r=5 il=0", r, il);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] r;
        logic z, il;
        int lat;
        @(negedge clk);
        ALUControl = 4'd4;
        op_a = 32'd1;
        op_b = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`ifndef EXEC_ALU_FAST_SHIFT_EN
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL shift_busy got rdy=%b v=%b want rdy=0 v=0",
                     in_ready, out_valid);
        end
`endif
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid got v=%b r=%h rdy=%b want v=0 r=0 rdy=1",
                     out_valid, result, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_lost got v=%b want 0", out_valid);
        end
        do_op(4'd0, 32'd100, 32'd23, r, z, il, lat);
        checks++;
        if (r !== 32'd123 || z !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL rst_recover got r=%h z=%b lat=%0d want r=7b z=0 lat=1",
                     r, z, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r;
        @(negedge clk);
        ALUControl = 4'd0;
        op_b = 32'd1000;
        op_a = 32'd1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        exp_r = 32'd0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (k % 2 == 1) begin
                exp_r = op_a + 32'd1000;
                if (out_valid !== 1'b1 || result !== exp_r) begin
                    errors++;
                    $display("FAIL b2b_%0d got v=%b r=%h want v=1 r=%h",
                             k, out_valid, result, exp_r);
                end
            end else begin
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_%0d got v=%b rdy=%b want v=0 rdy=1",
                             k, out_valid, in_ready);
                end
            end
            op_a = op_a + 32'd7;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, er;
        logic [3:0] op;
        logic z, il;
        int lat, el;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (i % 5 == 0) a = b;
            er = ref_res(op, a, b);
            el = ref_lat(op, b);
            do_op(op, a, b, r, z, il, lat);
            checks++;
            if (r !== er || z !== (er == 32'd0) || il !== (op >= 4'd10) ||
                lat !== el) begin
                errors++;
                $display("FAIL rand%0d op=%h a=%h b=%h got r=%h z=%b il=%b lat=%0d want r=%h lat=%0d",
                         i, op, a, b, r, z, il, lat, er, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_backpressure();
        test_illegal();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
